// File: rtl/pattern3_merge_pipe_if.sv
// Beat-level handshake and pattern-3 data bus; master = pattern source side, slave = merge pipe.
interface pattern3_merge_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] g1, g2, in2, in4, in5, in7, in8, in10, in11;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] n_429_or_0, g78, n_576, n_102, n_547;

  modport master (
    output in_valid, g1, g2, in2, in4, in5, in7, in8, in10, in11, out_ready,
    input  in_ready, out_valid, n_429_or_0, g78, n_576, n_102, n_547
  );

  modport slave (
    input  in_valid, g1, g2, in2, in4, in5, in7, in8, in10, in11, out_ready,
    output in_ready, out_valid, n_429_or_0, g78, n_576, n_102, n_547
  );
endinterface

// File: rtl/pattern3_merge_pipe.sv
// WIDTH-lane pattern-3 cell into a STAGES-slot elastic pipe; STAGES-cycle latency, stalls upstream only when full.
// PATTERN3_MERGE_PIPE_STATS_EN adds saturating transfer/stall counters.
module pattern3_merge_pipe #(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 2,
  parameter bit G78_INIT = 1'b0
) (
  input  logic                blif_clk_net,
  input  logic                blif_reset_net,
  pattern3_merge_pipe_if.slave io
`ifdef PATTERN3_MERGE_PIPE_STATS_EN
  ,
  output logic [31:0]         stat_beats,
  output logic [31:0]         stat_stalls
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] n_429_or_0;
    logic [WIDTH-1:0] g78;
    logic [WIDTH-1:0] n_576;
    logic [WIDTH-1:0] n_102;
    logic [WIDTH-1:0] n_547;
  } res_t;

  res_t              in_res;
  logic [WIDTH-1:0]  n_431;
  logic [WIDTH-1:0]  hist_q, hist_d;
  logic [STAGES-1:0] vld_q, vld_d, drn, src_vld;
  logic [STAGES:0]   ld;
  res_t              slot_q  [STAGES];
  res_t              slot_d  [STAGES];
  res_t              src_dat [STAGES];
  logic              in_fire;

  always_comb begin
    in_res.n_429_or_0 = ~(io.g1 & ~io.in5);
    in_res.g78        = hist_q;
    in_res.n_576      = ~(io.in7 & ~io.g2 & io.in5);
    in_res.n_102      = ~io.g2;
    in_res.n_547      = ~(io.in11 & ~io.g2 & ~io.in10);
    n_431             = io.in8 | (io.in2 & ~io.in4 & io.g1);
  end

  // ld[STAGES] stands for the consumer, so every slot drains when the next one loads.
  always_comb begin
    ld         = '0;
    drn        = '0;
    ld[STAGES] = io.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      drn[k] = vld_q[k] & ld[k+1];
      ld[k]  = ~vld_q[k] | drn[k];
    end
    in_fire = io.in_valid & ld[0];
  end

  always_comb begin
    src_vld[0] = io.in_valid;
    src_dat[0] = in_res;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_dat[k] = slot_q[k-1];
    end
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) begin
      slot_d[k] = slot_q[k];
      if (ld[k]) begin
        // An empty slot is kept zeroed so the output buses read 0 when idle.
        vld_d[k]  = src_vld[k];
        slot_d[k] = src_vld[k] ? src_dat[k] : '0;
      end
    end
    hist_d = in_fire ? n_431 : hist_q;
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      vld_q  <= '0;
      hist_q <= {WIDTH{G78_INIT}};
      for (int k = 0; k < STAGES; k++) slot_q[k] <= '0;
    end else begin
      vld_q  <= vld_d;
      hist_q <= hist_d;
      for (int k = 0; k < STAGES; k++) slot_q[k] <= slot_d[k];
    end
  end

  assign io.in_ready   = ld[0];
  assign io.out_valid  = vld_q[STAGES-1];
  assign io.n_429_or_0 = slot_q[STAGES-1].n_429_or_0;
  assign io.g78        = slot_q[STAGES-1].g78;
  assign io.n_576      = slot_q[STAGES-1].n_576;
  assign io.n_102      = slot_q[STAGES-1].n_102;
  assign io.n_547      = slot_q[STAGES-1].n_547;

`ifdef PATTERN3_MERGE_PIPE_STATS_EN
  logic [31:0] stat_beats_q, stat_beats_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_beats_d  = stat_beats_q;
    stat_stalls_d = stat_stalls_q;
    if (vld_q[STAGES-1] & io.out_ready & (stat_beats_q != 32'hFFFF_FFFF))
      stat_beats_d = stat_beats_q + 32'd1;
    if (vld_q[STAGES-1] & ~io.out_ready & (stat_stalls_q != 32'hFFFF_FFFF))
      stat_stalls_d = stat_stalls_q + 32'd1;
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      stat_beats_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_beats_q  <= stat_beats_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_beats  = stat_beats_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule
